fifo_word_serializer: RTL and testbench
=======================================

FIFO_WORD_SERIALIZER -- requirements
Module: fifo_word_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of one FIFO word; fixed at 32 for this release.
REQ-002 SHALL have parameter MSB_FIRST, default 1, meaning 1 = byte [31:24] sent first, 0 = byte [7:0] sent first.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset: 0 resets immediately, 1 runs.
REQ-005 SHALL have port en, input, 1, active-high enable for starting new FIFO reads.
REQ-006 SHALL have port fifo_empty, input, 1, empty flag from the upstream synchronous FIFO.
REQ-007 SHALL have port fifo_data, input, 32, FIFO read data, valid the cycle after a fifo_rd_en pulse.
REQ-008 SHALL have port fifo_rd_en, output, 1, one-cycle read strobe to the FIFO.
REQ-009 SHALL have port byte_out, output, 8, serialized byte.
REQ-010 SHALL have port byte_valid, output, 1, byte_out holds a byte for the downstream consumer.
REQ-011 SHALL have port byte_ready, input, 1, downstream accepts; a transfer occurs on a cycle where byte_valid=1 and byte_ready=1.
REQ-012 SHALL have port byte_last, output, 1, high with the 4th byte of each word.
REQ-013 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port word_count, output, 16, count of fully transmitted words.

Function
REQ-015 SHALL implement a four-state FSM: IDLE, READ, LOAD, SEND.
REQ-016 In IDLE with en=1 and fifo_empty=0, SHALL assert fifo_rd_en for exactly one cycle and move to READ.
REQ-017 In IDLE otherwise, SHALL keep fifo_rd_en=0 and remain in IDLE.
REQ-018 READ SHALL last exactly one cycle, with fifo_rd_en=0, and move to LOAD; this absorbs the FIFO's one-cycle read latency.
REQ-019 In LOAD, SHALL capture fifo_data into a 32-bit shift register, clear byte index to 0, and move to SEND.
REQ-020 In SEND, SHALL drive byte_valid=1 and byte_out = byte[index] in MSB_FIRST order.
REQ-021 In SEND, byte_last SHALL be 1 when index=3.
REQ-022 Once byte_valid=1, byte_out and byte_last SHALL be held stable until the transfer; byte_valid SHALL NOT drop before the transfer.
REQ-023 On a transfer with index<3, SHALL increment index and stay in SEND; the next byte is valid the following cycle.
REQ-024 On a transfer with index=3, SHALL increment word_count and return to IDLE.
REQ-025 word_count SHALL be modulo 2^16: 0xFFFF+1 -> 0x0000.
REQ-026 Latency SHALL be: fifo_rd_en at cycle N, first byte_valid at N+3.
REQ-027 Back-to-back throughput SHALL be one word per 4 transfer cycles plus 3 overhead cycles.
REQ-028 fifo_rd_en SHALL never be asserted while fifo_empty=1, and never outside IDLE.
REQ-029 en=0 SHALL block only new reads: a word already in READ, LOAD or SEND SHALL complete normally.
REQ-030 byte_ready=0 in SEND SHALL stall indefinitely with no loss or duplication of bytes.
REQ-031 Changes on fifo_empty outside IDLE SHALL be ignored.
REQ-032 Outside SEND, byte_valid and byte_last SHALL be 0.

Reset
REQ-033 reset=0 SHALL asynchronously force: state=IDLE, fifo_rd_en=0, byte_valid=0, byte_last=0, byte_out=0x00, index=0, shift register=0, word_count=0, busy=0.
REQ-034 Reset asserted mid-word SHALL discard the partial word; the first cycle after release SHALL be IDLE.
REQ-035 fifo_rd_en SHALL NOT pulse in the cycle reset deasserts; it may pulse on the next rising edge at the earliest.

Verification
REQ-036 MSB_FIRST=1, FIFO holds 0xA1B2C3D4, byte_ready=1, en=1 -> bytes A1,B2,C3,D4 on 4 consecutive cycles, byte_last only with D4, word_count 0->1.
REQ-037 MSB_FIRST=0, same word -> bytes D4,C3,B2,A1.
REQ-038 byte_ready toggled 1,0,0,1,... during SEND -> each byte held while ready=0, no drop or repeat, exactly 4 transfers.
REQ-039 fifo_empty=1, en=1 for 20 cycles -> fifo_rd_en never asserted, busy=0; en=0 with 3 words queued -> no reads.
REQ-040 reset pulled low after 2nd byte of 0x11223344 -> outputs zero immediately, word_count=0; after release the next word starts from its first byte.
REQ-041 word_count preloaded by sending 65536 words -> wraps to 0x0000 on the 65536th byte_last transfer.

Source files
------------

// File: rtl/fifo_word_serializer.sv
// fifo_word_serializer: pops 32-bit words from a synchronous FIFO
// and streams them out one byte at a time over a valid/ready port.
module fifo_word_serializer #(
    parameter int DATA_W    = 32,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    input  logic              byte_ready,
    output logic              byte_last,
    output logic              busy,
    output logic [15:0]       word_count
);

    localparam int NB = DATA_W / 8;
    localparam int IW = $clog2(NB);
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LOAD = 2'd2,
        S_SEND = 2'd3
    } state_t;

    state_t            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [IW-1:0]     idx_q;
    logic [7:0]        byte_q;
    logic              valid_q;
    logic              last_q;
    logic              busy_q;
    logic [15:0]       count_q;
    logic              armed_q;

    logic rd_go;
    logic xfer;

    // Byte that leaves next from a given word, in configured order.
    function automatic logic [7:0] head_byte(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) head_byte = w[DATA_W-1 -: 8];
        else           head_byte = w[7:0];
    endfunction

    // Word with its head byte consumed.
    function automatic logic [DATA_W-1:0] drop_byte(input logic [DATA_W-1:0] w);
        if (MSB_FIRST) drop_byte = w << 8;
        else           drop_byte = w >> 8;
    endfunction

    // armed_q keeps the read strobe quiet in the cycle reset releases.
    assign rd_go = (state_q == S_IDLE) && armed_q && en && !fifo_empty;
    assign xfer  = valid_q && byte_ready;

    assign fifo_rd_en = rd_go;
    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign byte_last  = last_q;
    assign busy       = busy_q;
    assign word_count = count_q;

    // Main FSM: read strobe, FIFO latency slot, capture, byte streaming.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            count_q <= 16'h0000;
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (rd_go) begin
                        state_q <= S_READ;
                        busy_q  <= 1'b1;
                    end
                end
                S_READ: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    shift_q <= drop_byte(fifo_data);
                    byte_q  <= head_byte(fifo_data);
                    idx_q   <= '0;
                    valid_q <= 1'b1;
                    last_q  <= 1'b0;
                    state_q <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        if (idx_q == LAST_IDX) begin
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            byte_q  <= 8'h00;
                            busy_q  <= 1'b0;
                            count_q <= count_q + 16'd1;
                            state_q <= S_IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            byte_q  <= head_byte(shift_q);
                            shift_q <= drop_byte(shift_q);
                            last_q  <= (idx_q == LAST_IDX - 1'b1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: both byte orders driven in lockstep,
// bytes scored against a queue-based model of the FIFO contents.
module tb_fifo_word_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [31:0] fifo_data = 32'h0;
    logic        byte_ready = 1'b0;

    logic        rd [2];
    logic [7:0]  bo [2];
    logic        bv [2];
    logic        bl [2];
    logic        bz [2];
    logic [15:0] wc [2];

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] fq [$];
    logic [8:0]  eq0 [$];
    logic [8:0]  eq1 [$];

    logic        rd_pend = 1'b0;
    int          cyc = 0;
    int          pend [2] = '{-1, -1};
    logic        pv [2] = '{1'b0, 1'b0};
    logic        held [2] = '{1'b0, 1'b0};
    logic [9:0]  hold [2];
    logic [15:0] wcm [2] = '{16'h0, 16'h0};
    logic [8:0]  e;
    logic        qe;

    always #5 clk = ~clk;

    fifo_word_serializer #(.DATA_W(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .en(en),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd[0]), .byte_out(bo[0]),
        .byte_valid(bv[0]), .byte_ready(byte_ready),
        .byte_last(bl[0]), .busy(bz[0]), .word_count(wc[0])
    );

    fifo_word_serializer #(.DATA_W(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .en(en),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(rd[1]), .byte_out(bo[1]),
        .byte_valid(bv[1]), .byte_ready(byte_ready),
        .byte_last(bl[1]), .busy(bz[1]), .word_count(wc[1])
    );

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    // Monitor: samples after inputs settle, i.e. the values the
    // next rising edge will see.
    always @(negedge clk) begin
        #1;
        cyc++;
        if (!reset) begin
            rd_pend = 1'b0;
            for (int d = 0; d < 2; d++) begin
                held[d] = 1'b0;
                pend[d] = -1;
                pv[d]   = 1'b0;
            end
        end else begin
            rd_pend = rd[0];
            for (int d = 0; d < 2; d++) begin
                if (rd[d]) begin
                    chk("rd_while_empty", 32'(fifo_empty), 32'd0);
                    chk("rd_while_busy", 32'(bz[d]), 32'd0);
                    pend[d] = cyc + 3;
                end
                if (bv[d] && !pv[d])
                    chk("first_byte_latency", cyc, pend[d]);
                if (held[d])
                    chk("hold_stable", {22'd0, bv[d], bl[d], bo[d]},
                        {22'd0, hold[d]});
                if (!bv[d])
                    chk("last_without_valid", 32'(bl[d]), 32'd0);
                chk("word_count", 32'(wc[d]), 32'(wcm[d]));
                if (bv[d] && byte_ready) begin
                    qe = 1'b0;
                    e  = '0;
                    if (d == 0) begin
                        if (eq0.size() == 0) qe = 1'b1;
                        else e = eq0.pop_front();
                    end else begin
                        if (eq1.size() == 0) qe = 1'b1;
                        else e = eq1.pop_front();
                    end
                    if (qe) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_byte: dut%0d got %0h expected none",
                                 d, bo[d]);
                    end else begin
                        chk("byte", {23'd0, bl[d], bo[d]}, {23'd0, e});
                        if (e[8]) wcm[d] = wcm[d] + 16'd1;
                    end
                    held[d] = 1'b0;
                end else if (bv[d]) begin
                    held[d] = 1'b1;
                    hold[d] = {1'b1, bl[d], bo[d]};
                end else begin
                    held[d] = 1'b0;
                end
                pv[d] = bv[d];
            end
        end
    end

    // Upstream FIFO model: pops on the edge that sampled the strobe.
    task automatic step();
        @(negedge clk);
        if (rd_pend && fq.size() > 0) fifo_data = fq.pop_front();
        rd_pend    = 1'b0;
        fifo_empty = (fq.size() == 0);
    endtask

    task automatic push_word(input logic [31:0] w);
        fq.push_back(w);
        for (int i = 0; i < 4; i++) begin
            eq0.push_back({i == 3, 8'(w >> (24 - 8 * i))});
            eq1.push_back({i == 3, 8'(w >> (8 * i))});
        end
        fifo_empty = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (!(eq0.size() == 0 && eq1.size() == 0 && fq.size() == 0
                 && !bz[0] && !bz[1]) && n < budget) begin
            step();
            n++;
        end
        chk("drain_in_budget", 32'(n < budget), 32'd1);
    endtask

    task automatic chk_zero(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk({tag, "_rd"}, 32'(rd[d]), 32'd0);
            chk({tag, "_byte"}, 32'(bo[d]), 32'd0);
            chk({tag, "_valid"}, 32'(bv[d]), 32'd0);
            chk({tag, "_last"}, 32'(bl[d]), 32'd0);
            chk({tag, "_busy"}, 32'(bz[d]), 32'd0);
            chk({tag, "_count"}, 32'(wc[d]), 32'd0);
        end
    endtask

    logic [7:0] msb_b [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [7:0] lsb_b [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};
    logic       tog [4]   = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int n;
        // Reset state.
        step();
        step();
        #1;
        chk_zero("reset");

        // Release with a word waiting: no strobe in the release cycle.
        push_word(32'hA1B2C3D4);
        en = 1'b1;
        byte_ready = 1'b1;
        step();
        reset = 1'b1;
        #1;
        chk("release_rd0", 32'(rd[0]), 32'd0);
        chk("release_rd1", 32'(rd[1]), 32'd0);

        // Four consecutive bytes in both orders.
        n = 0;
        while (!bv[0] && n < 12) begin
            step();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            chk("p1_valid", 32'(bv[0]), 32'd1);
            chk("p1_msb", 32'(bo[0]), 32'(msb_b[i]));
            chk("p1_lsb", 32'(bo[1]), 32'(lsb_b[i]));
            chk("p1_last", 32'(bl[0]), 32'(i == 3));
            step();
        end
        chk("p1_count_msb", 32'(wc[0]), 32'd1);
        chk("p1_count_lsb", 32'(wc[1]), 32'd1);
        wait_drain(20);

        // Backpressure pattern.
        push_word(32'h55667788);
        for (int i = 0; i < 40; i++) begin
            step();
            byte_ready = tog[i % 4];
        end
        byte_ready = 1'b1;
        wait_drain(40);

        // Empty FIFO with enable set: no reads, stays idle.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("empty_rd", 32'(rd[0]), 32'd0);
            chk("empty_busy", 32'(bz[0]), 32'd0);
        end

        // Disabled with words queued: no reads.
        en = 1'b0;
        push_word(32'h01020304);
        push_word(32'hF0E0D0C0);
        push_word(32'h0BADBEEF);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("dis_rd0", 32'(rd[0]), 32'd0);
            chk("dis_rd1", 32'(rd[1]), 32'd0);
            chk("dis_busy", 32'(bz[0]), 32'd0);
        end
        en = 1'b1;
        wait_drain(100);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step();
            en = ($urandom_range(0, 3) != 0);
            byte_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 5) == 0 && fq.size() < 8)
                push_word($urandom);
        end
        en = 1'b1;
        byte_ready = 1'b1;
        wait_drain(300);

        // Reset after the second byte of a word.
        push_word(32'h11223344);
        push_word(32'hCAFEF00D);
        n = 0;
        while (!bv[0] && n < 12) begin
            step();
            n++;
        end
        step();
        step();
        reset = 1'b0;
        void'(eq0.pop_front());
        void'(eq0.pop_front());
        void'(eq1.pop_front());
        void'(eq1.pop_front());
        wcm[0] = 16'h0;
        wcm[1] = 16'h0;
        #1;
        chk_zero("midreset");
        step();
        step();
        reset = 1'b1;
        #1;
        chk("rerelease_busy", 32'(bz[0]), 32'd0);
        chk("rerelease_rd", 32'(rd[0]), 32'd0);
        wait_drain(40);
        chk("final_count", 32'(wc[0]), 32'(wcm[0]));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
